div: RTL and testbench



---
 rtl/div.sv | 140 ++++++++++++++
 tb/tb_div.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} with ready_o; holds the result until start_i drops.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 6;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_BYZERO,
    ST_ON,
    ST_END
  } state_t;

  state_t             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*DataW:0]   dividend_q, dividend_d;
  logic [DataW-1:0]   divisor_q, divisor_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic [2*DataW-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [DataW:0]     trial;
  logic [DataW-1:0]   mag1, mag2;
  logic [DataW-1:0]   quot, rem;

  // Operand magnitudes and the trial subtraction of the current partial remainder
  always_comb begin
    mag1  = (signed_div_i && opdata1_i[DataW-1]) ? DataW'(32'd0 - opdata1_i) : opdata1_i;
    mag2  = (signed_div_i && opdata2_i[DataW-1]) ? DataW'(32'd0 - opdata2_i) : opdata2_i;
    trial = {1'b0, dividend_q[2*DataW-1:DataW]} - {1'b0, divisor_q};
    quot  = (s1_q ^ s2_q) ? DataW'(32'd0 - dividend_q[DataW-1:0]) : dividend_q[DataW-1:0];
    rem   = s1_q ? DataW'(32'd0 - dividend_q[2*DataW:DataW+1]) : dividend_q[2*DataW:DataW+1];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    result_d   = result_q;
    ready_d    = ready_q;

    unique case (state_q)
      ST_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d    = ST_ON;
            cnt_d      = '0;
            s1_d       = signed_div_i & opdata1_i[DataW-1];
            s2_d       = signed_div_i & opdata2_i[DataW-1];
            dividend_d = {32'd0, mag1, 1'b0};
            divisor_d  = mag2;
          end
        end
      end

      ST_BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = ST_END;
      end

      ST_ON: begin
        if (annul_i) begin
          state_d  = ST_FREE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q < CntW'(DataW)) begin
          if (trial[DataW]) begin
            dividend_d = {dividend_q[2*DataW-1:0], 1'b0};
          end else begin
            dividend_d = {trial[DataW-1:0], dividend_q[DataW-1:0], 1'b1};
          end
          cnt_d = cnt_q + CntW'(1);
        end else begin
          result_d = {rem, quot};
          ready_d  = 1'b1;
          state_d  = ST_END;
          cnt_d    = '0;
        end
      end

      ST_END: begin
        // annul_i releases the result just like a dropped start_i
        if (!start_i || annul_i) begin
          ready_d  = 1'b0;
          result_d = '0;
          state_d  = ST_FREE;
        end
      end

      default: state_d = ST_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the div block.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a request and wait (bounded) for ready; operands are scrambled after capture
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res);
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    annul = 1'b0;
    @(posedge clk); #1;
    op1 = 32'hA5A5_5A5A;
    op2 = 32'h0000_0003;
    signed_div = ~s;
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_values: ready=%b result=%h want ready=0 result=0", ready, result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_divide(input string name, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    logic [63:0] res;
    logic held;
    do_div(s, a, b, lat, res);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, res, exp);
    end
    held = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready !== 1'b1 || result !== exp) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s hold: ready=%b result=%h want ready=1 result=%h", name, ready, result, exp);
    end
    drop_start();
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL %s release: ready=%b result=%h want ready=0 result=0", name, ready, result);
    end
  endtask

  task automatic test_annul();
    logic seen;
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    annul = 1'b0;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = ready;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL annul_e10: ready rose=%b want 0", seen);
    end
    annul = 1'b0;
    test_divide("after_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
  endtask

  task automatic test_annul_at_last();
    logic seen;
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    annul = 1'b0;
    @(posedge clk);
    repeat (32) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    seen = ready;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    checks++;
    if (seen !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL annul_e33: ready rose=%b result=%h want 0/0", seen, result);
    end
    annul = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_end_annul();
    int lat;
    logic [63:0] res;
    do_div(1'b0, 32'd100, 32'd7, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL end_annul_setup: lat=%0d result=%h want 33 %h", lat, res, 64'h00000002_0000000E);
    end
    annul = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL end_annul: ready=%b result=%h want 0/0", ready, result);
    end
    annul = 1'b0;
    drop_start();
  endtask

  task automatic test_reset_midflight();
    logic seen;
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    annul = 1'b0;
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    op2 = 32'd0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_e20: ready=%b result=%h want 0/0", ready, result);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_blocks_request: ready rose=%b want 0", seen);
    end
    test_divide("after_reset", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divide("udiv_100_7",   1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33);
    test_divide("sdiv_m7_2",    1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 33);
    test_divide("sdiv_7_m2",    1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33);
    test_divide("sdiv_m100_m7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 33);
    test_divide("sdiv_min_m1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33);
    test_divide("udiv_max_1",   1'b0, 32'hFFFFFFFF,  32'h00000001,  64'h00000000_FFFFFFFF, 33);
    test_divide("udiv_max_16",  1'b0, 32'hFFFFFFFF,  32'h00000010,  64'h0000000F_0FFFFFFF, 33);
    test_divide("udiv_5_9",     1'b0, 32'd5,         32'd9,         64'h00000005_00000000, 33);
    test_divide("div_by_zero",  1'b0, 32'd12,        32'd0,         64'h00000000_00000000, 1);
    test_annul();
    test_annul_at_last();
    test_end_annul();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
